// File: rtl/palette_cycle_ctrl.sv
// Sole bus master for the 8x4x24b palette: arbitrates CPU Avalon accesses against a colour-cycling engine.
// Optional feature macro: PALCYC_REVERSE_EN adds cycle_reverse_i (reverse rotation direction).
module palette_cycle_ctrl #(
  parameter int PERIOD_W = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                clk_100_i,
  input  logic                reset_n_i,
  input  logic                cpu_cs_i,
  input  logic                cpu_read_i,
  input  logic                cpu_write_i,
  input  logic [4:0]          cpu_addr_i,
  input  logic [31:0]         cpu_writedata_i,
  input  logic [3:0]          cpu_byte_en_i,
  output logic [31:0]         cpu_readdata_o,
  output logic                cpu_waitrequest_o,
  output logic                pal_cs_o,
  output logic                pal_read_o,
  output logic                pal_write_o,
  output logic [4:0]          pal_addr_o,
  output logic [31:0]         pal_writedata_o,
  output logic [3:0]          pal_byte_en_o,
  input  logic [31:0]         pal_readdata_i,
  input  logic                vsync_pulse_i,
  input  logic [7:0]          cycle_mask_i,
  input  logic [PERIOD_W-1:0] cycle_period_i,
`ifdef PALCYC_REVERSE_EN
  input  logic                cycle_reverse_i,
`endif
  output logic                busy_o
);

  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    WR    = 3'd4,
    NEXT  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          mask_q, mask_d;
  logic [2:0]          p_q, p_d;
  logic [1:0]          i_q, i_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [23:0]         c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [PERIOD_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                pend_q, pend_d;
  logic                rev_s;
  logic                cpu_req_s, cpu_pass_s, eng_rd_s, eng_wr_s, hold_s, busy_s;
  logic [PERIOD_W:0]   frame_inc_s;
  logic [23:0]         wr_color_s;

`ifdef PALCYC_REVERSE_EN
  logic rev_q, rev_d;
  assign rev_s = rev_q;
`else
  assign rev_s = 1'b0;
`endif

  assign cpu_req_s      = cpu_cs_i & (cpu_read_i | cpu_write_i);
  assign busy_s         = pend_q | (state_q != IDLE);
  assign busy_o         = busy_s;
  assign cpu_readdata_o = pal_readdata_i;
  assign cpu_waitrequest_o = hold_s;
  assign frame_inc_s    = {1'b0, frame_cnt_q} + {{PERIOD_W{1'b0}}, 1'b1};

  // Frame counter; a trigger that lands while a rotation is pending or running is dropped
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    pend_d      = pend_q;
    if ((state_q == IDLE) && pend_q) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (vsync_pulse_i && (cycle_period_i != {PERIOD_W{1'b0}})) begin
      if (frame_inc_s >= {1'b0, cycle_period_i}) begin
        frame_cnt_d = {PERIOD_W{1'b0}};
        if (!busy_s) begin
          pend_d = 1'b1;
        end else begin
          pend_d = pend_d;
        end
      end else begin
        frame_cnt_d = frame_inc_s[PERIOD_W-1:0];
      end
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Colour written back for slot i: captured colours are stable through WR, so old values are used
  always_comb begin
    case (i_q)
      2'd1:    wr_color_s = rev_s ? c3_q : c2_q;
      2'd2:    wr_color_s = rev_s ? c1_q : c3_q;
      default: wr_color_s = rev_s ? c2_q : c1_q;
    endcase
  end

  // Engine next-state logic and bus ownership
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    p_d        = p_q;
    i_d        = i_q;
    wait_d     = wait_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    c3_d       = c3_q;
`ifdef PALCYC_REVERSE_EN
    rev_d      = rev_q;
`endif
    cpu_pass_s = 1'b0;
    eng_rd_s   = 1'b0;
    eng_wr_s   = 1'b0;
    hold_s     = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_pass_s = 1'b1;
        if (pend_q) begin
          mask_d  = cycle_mask_i;
          p_d     = 3'd0;
`ifdef PALCYC_REVERSE_EN
          rev_d   = cycle_reverse_i;
`endif
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (cpu_req_s) begin
          cpu_pass_s = 1'b1;
          state_d    = SCAN;
        end else if (mask_q[p_q]) begin
          i_d     = 2'd1;
          state_d = RD;
        end else begin
          state_d = NEXT;
        end
      end
      RD: begin
        hold_s   = 1'b1;
        eng_rd_s = 1'b1;
        wait_d   = WAIT_W'(RD_LAT - 1);
        state_d  = RWAIT;
      end
      RWAIT: begin
        hold_s = 1'b1;
        if (wait_q == {WAIT_W{1'b0}}) begin
          case (i_q)
            2'd1:    c1_d = pal_readdata_i[23:0];
            2'd2:    c2_d = pal_readdata_i[23:0];
            default: c3_d = pal_readdata_i[23:0];
          endcase
          if (i_q != 2'd3) begin
            i_d     = i_q + 2'd1;
            state_d = RD;
          end else begin
            i_d     = 2'd1;
            state_d = WR;
          end
        end else begin
          wait_d = wait_q - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      WR: begin
        hold_s   = 1'b1;
        eng_wr_s = 1'b1;
        if (i_q == 2'd3) begin
          state_d = NEXT;
        end else begin
          i_d = i_q + 2'd1;
        end
      end
      NEXT: begin
        hold_s = 1'b1;
        if (p_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          p_d     = p_q + 3'd1;
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Palette port mux; the CPU path is gated by reset so every strobe drops the moment reset asserts
  always_comb begin
    pal_cs_o        = 1'b0;
    pal_read_o      = 1'b0;
    pal_write_o     = 1'b0;
    pal_addr_o      = 5'd0;
    pal_writedata_o = 32'd0;
    pal_byte_en_o   = 4'd0;
    if (cpu_pass_s && reset_n_i) begin
      pal_cs_o        = cpu_cs_i;
      pal_read_o      = cpu_read_i;
      pal_write_o     = cpu_write_i;
      pal_addr_o      = cpu_addr_i;
      pal_writedata_o = cpu_writedata_i;
      pal_byte_en_o   = cpu_byte_en_i;
    end else if (eng_rd_s) begin
      pal_cs_o   = 1'b1;
      pal_read_o = 1'b1;
      pal_addr_o = {p_q, i_q};
    end else if (eng_wr_s) begin
      pal_cs_o        = 1'b1;
      pal_write_o     = 1'b1;
      pal_addr_o      = {p_q, i_q};
      pal_writedata_o = {8'h00, wr_color_s};
      pal_byte_en_o   = 4'b0111;
    end else begin
      pal_cs_o = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk_100_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      mask_q      <= 8'd0;
      p_q         <= 3'd0;
      i_q         <= 2'd0;
      wait_q      <= {WAIT_W{1'b0}};
      c1_q        <= 24'd0;
      c2_q        <= 24'd0;
      c3_q        <= 24'd0;
      frame_cnt_q <= {PERIOD_W{1'b0}};
      pend_q      <= 1'b0;
`ifdef PALCYC_REVERSE_EN
      rev_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      p_q         <= p_d;
      i_q         <= i_d;
      wait_q      <= wait_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      c3_q        <= c3_d;
      frame_cnt_q <= frame_cnt_d;
      pend_q      <= pend_d;
`ifdef PALCYC_REVERSE_EN
      rev_q       <= rev_d;
`endif
    end
  end

endmodule
